// File: rtl/spi_frame_sched.sv
// spi_frame_sched
//   Per-frame scheduler for the SPI master datapath. One SPI link is shared
//   among N_REQ requesters, arbitrated round-robin at every frame boundary.
//   The winner's word is serialized MSB first on MOSI (SPI mode 0), MISO is
//   captured, and the received word is returned tagged with the winner's ID.
//   SCLK is gated by the master and runs only while CS is low.
// Ports
//   SCLK        serial clock (gated)
//   rst         asynchronous active-high reset
//   CS          active-low chip select; high asynchronously clears frame state
//   req_i       level request per requester
//   tx_data_i   requester k word at [k*F_SIZE +: F_SIZE]
//   MISO        serial data from slave, sampled on posedge SCLK
//   MOSI        serial data to slave, MSB first
//   grant_o     one-hot owner of current/last frame, 0 for an idle frame
//   rx_data_o   last received word of a granted frame
//   rx_id_o     requester ID owning rx_data_o
//   rx_tog_o    toggles once per received word of a granted frame
//   frame_cnt_o frames completed in the current transaction (saturating)
module spi_frame_sched #(
    parameter int                N_REQ     = 4,
    parameter int                F_SIZE    = 8,
    parameter int                F_NUM     = 4,
    parameter logic [F_SIZE-1:0] IDLE_WORD = {F_SIZE{1'b1}},
    parameter int                C_SIZE    = $clog2(F_SIZE) + 1,
    parameter int                FC_SIZE   = $clog2(F_NUM) + 1,
    parameter int                ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      SCLK,
    input  logic                      rst,
    input  logic                      CS,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*F_SIZE-1:0]   tx_data_i,
    input  logic                      MISO,
    output logic                      MOSI,
    output logic [N_REQ-1:0]          grant_o,
    output logic [F_SIZE-1:0]         rx_data_o,
    output logic [ID_W-1:0]           rx_id_o,
    output logic                      rx_tog_o,
    output logic [FC_SIZE-1:0]        frame_cnt_o
);

    // Cleared by CS high as well as rst
    logic [C_SIZE-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [FC_SIZE-1:0] frame_cnt_q, frame_cnt_d;
    // Only the low F_SIZE-1 bits of the shift register are ever observed,
    // so the MSB is not stored.
    logic [F_SIZE-2:0]  rx_sh_q,     rx_sh_d;

    // Cleared by rst only; hold across transactions
    logic [N_REQ-1:0]   grant_q,     grant_d;
    logic [ID_W-1:0]    ptr_q,       ptr_d;
    logic [F_SIZE-1:0]  tx_hold_q,   tx_hold_d;
    logic [F_SIZE-1:0]  rx_data_q,   rx_data_d;
    logic [ID_W-1:0]    rx_id_q,     rx_id_d;
    logic               rx_tog_q,    rx_tog_d;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [F_SIZE-1:0]  next_word;
    logic               tx_bit;
    logic               first_bit, last_bit;

    assign first_bit = (bit_cnt_q == '0);
    assign last_bit  = (bit_cnt_q == C_SIZE'(F_SIZE - 1));

    // Round-robin search starting just after the last winner
    always_comb begin
        found     = 1'b0;
        win       = ptr_q;
        next_word = IDLE_WORD;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!found && ((32'(ptr_q) + i) % N_REQ == k) && req_i[k]) begin
                    found     = 1'b1;
                    win       = ID_W'(k);
                    next_word = tx_data_i[k*F_SIZE +: F_SIZE];
                end
            end
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        for (int unsigned k = 0; k < F_SIZE; k++) begin
            if (bit_cnt_q == C_SIZE'(k)) begin
                tx_bit = tx_hold_q[F_SIZE-1-k];
            end
        end
    end

    // At bit 0 the held word is not loaded yet, so the MSB comes straight
    // from the arbitration result.
    assign MOSI = CS ? 1'b1 : (first_bit ? next_word[F_SIZE-1] : tx_bit);

    always_comb begin
        bit_cnt_d   = last_bit ? '0 : bit_cnt_q + 1'b1;
        frame_cnt_d = frame_cnt_q;
        if (last_bit && (frame_cnt_q != FC_SIZE'(F_NUM))) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        rx_sh_d = {rx_sh_q[F_SIZE-3:0], MISO};

        grant_d   = grant_q;
        ptr_d     = ptr_q;
        tx_hold_d = tx_hold_q;
        if (first_bit) begin
            grant_d   = N_REQ'(found) << win;
            tx_hold_d = next_word;
            if (found) begin
                ptr_d = win;
            end
        end

        // During a granted frame ptr_q already holds the winner's ID
        rx_data_d = rx_data_q;
        rx_id_d   = rx_id_q;
        rx_tog_d  = rx_tog_q;
        if (last_bit && (grant_q != '0)) begin
            rx_data_d = {rx_sh_q, MISO};
            rx_id_d   = ptr_q;
            rx_tog_d  = ~rx_tog_q;
        end
    end

    always_ff @(posedge SCLK or posedge rst or posedge CS) begin
        if (rst || CS) begin
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            rx_sh_q     <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rx_sh_q     <= rx_sh_d;
        end
    end

    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            tx_hold_q <= IDLE_WORD;
            rx_data_q <= '0;
            rx_id_q   <= '0;
            rx_tog_q  <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            tx_hold_q <= tx_hold_d;
            rx_data_q <= rx_data_d;
            rx_id_q   <= rx_id_d;
            rx_tog_q  <= rx_tog_d;
        end
    end

    assign grant_o     = grant_q;
    assign rx_data_o   = rx_data_q;
    assign rx_id_o     = rx_id_q;
    assign rx_tog_o    = rx_tog_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_spi_frame_sched.sv
// Directed bench for spi_frame_sched with default parameters.
module tb_spi_frame_sched;

    logic        SCLK = 1'b0;
    logic        rst, CS, MISO, MOSI;
    logic        loop_en, miso_drv;
    logic [3:0]  req;
    logic [31:0] txd;
    logic [3:0]  grant;
    logic [7:0]  rxd;
    logic [1:0]  rxid;
    logic        tog;
    logic [2:0]  fc;
    logic [31:0] mosi_cap;
    int          n_cmp = 0;
    int          n_err = 0;

    assign MISO = loop_en ? MOSI : miso_drv;

    spi_frame_sched #(.N_REQ(4), .F_SIZE(8), .F_NUM(4)) dut (
        .SCLK(SCLK), .rst(rst), .CS(CS), .req_i(req), .tx_data_i(txd),
        .MISO(MISO), .MOSI(MOSI), .grant_o(grant), .rx_data_o(rxd),
        .rx_id_o(rxid), .rx_tog_o(tog), .frame_cnt_o(fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One SCLK period; MOSI is captured just before the rising edge
    task automatic tick(input logic m);
        miso_drv = m;
        #4;
        mosi_cap = {mosi_cap[30:0], MOSI};
        #1 SCLK = 1'b1;
        #5 SCLK = 1'b0;
    endtask

    task automatic frame(input logic [7:0] pat);
        for (int i = 7; i >= 0; i--) tick(pat[i]);
        #1;
    endtask

    task automatic chk_frame(input string tag, input logic [3:0] g, input logic [7:0] d,
                             input logic [1:0] id, input logic t, input logic [2:0] f,
                             input logic [7:0] w);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".rx_data"}, 32'(rxd), 32'(d));
        check({tag, ".rx_id"}, 32'(rxid), 32'(id));
        check({tag, ".rx_tog"}, 32'(tog), 32'(t));
        check({tag, ".frame_cnt"}, 32'(fc), 32'(f));
        check({tag, ".mosi"}, 32'(mosi_cap[7:0]), 32'(w));
    endtask

    initial begin
        rst = 1'b1; CS = 1'b1; req = 4'h0; loop_en = 1'b1; miso_drv = 1'b0;
        mosi_cap = '0;
        txd = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #10;
        check("reset.grant", 32'(grant), 32'h0);
        check("reset.rx_data", 32'(rxd), 32'h0);
        check("reset.rx_id", 32'(rxid), 32'h0);
        check("reset.rx_tog", 32'(tog), 32'h0);
        check("reset.frame_cnt", 32'(fc), 32'h0);
        check("reset.MOSI", 32'(MOSI), 32'h1);
        rst = 1'b0; #5;

        // T1: all requesting, loopback
        req = 4'hF; CS = 1'b0; #5;
        frame(8'h00); chk_frame("T1f0", 4'b0001, 8'hA0, 2'd0, 1'b1, 3'd1, 8'hA0);
        frame(8'h00); chk_frame("T1f1", 4'b0010, 8'hA1, 2'd1, 1'b0, 3'd2, 8'hA1);
        frame(8'h00); chk_frame("T1f2", 4'b0100, 8'hA2, 2'd2, 1'b1, 3'd3, 8'hA2);
        frame(8'h00); chk_frame("T1f3", 4'b1000, 8'hA3, 2'd3, 1'b0, 3'd4, 8'hA3);
        CS = 1'b1; #5;
        check("T1cs.frame_cnt", 32'(fc), 32'h0);
        check("T1cs.MOSI", 32'(MOSI), 32'h1);
        check("T1cs.grant_hold", 32'(grant), 32'h8);

        // T2: idle frames
        req = 4'h0; CS = 1'b0; #5;
        frame(8'h00); frame(8'h00);
        check("T2.mosi16", 32'(mosi_cap[15:0]), 32'hFFFF);
        check("T2.grant", 32'(grant), 32'h0);
        check("T2.rx_tog", 32'(tog), 32'h0);
        check("T2.rx_data", 32'(rxd), 32'hA3);
        check("T2.frame_cnt", 32'(fc), 32'h2);
        CS = 1'b1; #5;

        // T3: two requesters alternate; ptr stayed at 3 through T2
        req = 4'b0101; CS = 1'b0; #5;
        frame(8'h00); chk_frame("T3f0", 4'b0001, 8'hA0, 2'd0, 1'b1, 3'd1, 8'hA0);
        frame(8'h00); chk_frame("T3f1", 4'b0100, 8'hA2, 2'd2, 1'b0, 3'd2, 8'hA2);
        frame(8'h00); chk_frame("T3f2", 4'b0001, 8'hA0, 2'd0, 1'b1, 3'd3, 8'hA0);
        frame(8'h00); chk_frame("T3f3", 4'b0100, 8'hA2, 2'd2, 1'b0, 3'd4, 8'hA2);
        CS = 1'b1; req = 4'hF; #5;
        CS = 1'b0; #5;
        frame(8'h00); chk_frame("T3b0", 4'b1000, 8'hA3, 2'd3, 1'b1, 3'd1, 8'hA3);
        frame(8'h00); chk_frame("T3b1", 4'b0001, 8'hA0, 2'd0, 1'b0, 3'd2, 8'hA0);
        frame(8'h00); chk_frame("T3b2", 4'b0010, 8'hA1, 2'd1, 1'b1, 3'd3, 8'hA1);
        frame(8'h00); chk_frame("T3b3", 4'b0100, 8'hA2, 2'd2, 1'b0, 3'd4, 8'hA2);
        frame(8'h00); chk_frame("T3b4sat", 4'b1000, 8'hA3, 2'd3, 1'b1, 3'd4, 8'hA3);
        CS = 1'b1; #5;

        // T4: transaction aborted after 5 bits
        CS = 1'b0; #5;
        for (int i = 0; i < 5; i++) tick(1'b0);
        #1;
        check("T4mid.grant", 32'(grant), 32'h1);
        CS = 1'b1; #5;
        check("T4abort.rx_tog", 32'(tog), 32'h1);
        check("T4abort.frame_cnt", 32'(fc), 32'h0);
        check("T4abort.rx_data", 32'(rxd), 32'hA3);
        check("T4abort.rx_id", 32'(rxid), 32'h3);
        check("T4abort.MOSI", 32'(MOSI), 32'h1);
        CS = 1'b0; #5;
        frame(8'h00); chk_frame("T4next", 4'b0010, 8'hA1, 2'd1, 1'b0, 3'd1, 8'hA1);

        // T5: reset at bit 3 of frame 1
        for (int i = 0; i < 3; i++) tick(1'b0);
        #1;
        check("T5mid.grant", 32'(grant), 32'h4);
        rst = 1'b1; #1;
        check("T5rst.grant", 32'(grant), 32'h0);
        check("T5rst.rx_data", 32'(rxd), 32'h0);
        check("T5rst.rx_id", 32'(rxid), 32'h0);
        check("T5rst.rx_tog", 32'(tog), 32'h0);
        check("T5rst.frame_cnt", 32'(fc), 32'h0);
        #3 rst = 1'b0; #2;
        frame(8'h00); chk_frame("T5post", 4'b0001, 8'hA0, 2'd0, 1'b1, 3'd1, 8'hA0);
        CS = 1'b1; #5;

        // T6: driven MISO patterns, idle frame then requester 1
        loop_en = 1'b0; req = 4'h0; CS = 1'b0; #5;
        frame(8'h5A); chk_frame("T6idle", 4'b0000, 8'hA0, 2'd0, 1'b1, 3'd1, 8'hFF);
        req = 4'b0010;
        frame(8'h3C); chk_frame("T6grant", 4'b0010, 8'h3C, 2'd1, 1'b0, 3'd2, 8'hA1);
        CS = 1'b1; #5;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
